serial_frame_tx: RTL and testbench

- Frame-based serial transmitter: the sending end of the team's serial capture path.
- Accepts a parallel word through a ready/load handshake and shifts it out on a single line, framed by a start bit and a stop bit.
- Each bit is held for a programmable number of clock cycles.
- Sits between parallel producer logic and the serial receiver built from the team's D storage elements.

---
 rtl/serial_frame_pkg.sv | 23 ++
 rtl/serial_frame_tx_bit_timer.sv | 45 ++++
 rtl/serial_frame_tx.sv | 162 ++++++++++++++++
 tb/tb_serial_frame_tx.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - shared types and constants for the serial frame transmitter
// FSM state encoding, serial line levels and a counter-width helper.
// Imported by serial_frame_tx and bit_timer.

package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic TXD_IDLE  = 1'b1;
    localparam logic TXD_START = 1'b0;

    // A counter over 0..n-1 needs clog2(n) bits, but never fewer than one.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// rtl/serial_frame_tx_bit_timer.sv - per-bit cycle timer, shared with the receiver side
// Counts 0..CLKS_PER_BIT-1 and wraps; tick marks the terminal count.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-low reset
//   clr  - hold the count at zero (tick suppressed while high)
//   tick - terminal count reached this cycle

module bit_timer
    import serial_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = !clr && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - start/stop framed serial transmitter, LSB first
// Optional even-parity bit compiled in with SERIAL_FRAME_TX_PARITY_EN.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-low reset
//   din   - parallel word, sampled on an accepted load
//   load  - request to send din
//   ready - load will be accepted this cycle (state is IDLE)
//   txd   - serial line, idle high (registered)
//   busy  - frame in progress (registered)
//   done  - one-cycle pulse after the last stop cycle (registered)

module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              load,
    output logic              ready,
    output logic              txd,
    output logic              busy,
    output logic              done
);

    localparam int IW = cnt_width(DATA_W);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic              tick;
    logic              timer_clr;
    logic [DATA_W-1:0] shifted;

    // The timer sits at zero in IDLE so every frame starts on a fresh bit period.
    assign timer_clr = (state_q == IDLE);
    assign shifted   = shreg_q >> 1;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk (clk),
        .rst (rst),
        .clr (timer_clr),
        .tick(tick)
    );

    // txd is registered, so each transition loads the level of the bit about to start.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
        txd_d    = txd_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                txd_d  = TXD_IDLE;
                busy_d = 1'b0;
                if (load) begin
                    state_d  = START;
                    shreg_d  = din;
                    idx_d    = '0;
                    txd_d    = TXD_START;
                    busy_d   = 1'b1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    // Parity is latched at capture because the shift register is consumed.
                    parity_d = ^din;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    txd_d   = shreg_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == LAST_IDX) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        state_d = PARITY;
                        txd_d   = parity_q;
`else
                        state_d = STOP;
                        txd_d   = TXD_IDLE;
`endif
                    end else begin
                        shreg_d = shifted;
                        idx_d   = idx_q + 1'b1;
                        txd_d   = shifted[0];
                    end
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    txd_d   = TXD_IDLE;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    txd_d   = TXD_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = TXD_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            idx_q    <= '0;
            txd_q    <= TXD_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            idx_q    <= idx_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign ready = (state_q == IDLE);
    assign txd   = txd_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - directed self-checking bench for serial_frame_tx

module tb_serial_frame_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic          clk  = 1'b0;
    logic          rst  = 1'b0;
    logic          load = 1'b0;
    logic [DW-1:0] din  = '0;
    logic          ready;
    logic          txd;
    logic          busy;
    logic          done;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    serial_frame_tx #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .load (load),
        .ready(ready),
        .txd  (txd),
        .busy (busy),
        .done (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Line levels in transmit order, bit 0 first.
    function automatic logic [11:0] frame_bits(input logic [7:0] d);
`ifdef SERIAL_FRAME_TX_PARITY_EN
        return {1'b0, 1'b1, ^d, d, 1'b0};
`else
        return {2'b00, 1'b1, d, 1'b0};
`endif
    endfunction

    // Called at a negedge; returns just after the accepting edge.
    task automatic launch(input string tag, input logic [7:0] d);
        din  = d;
        load = 1'b1;
        chk({tag, " ready"}, 32'(ready), 32'd1);
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    // Watches one whole frame and the done cycle after it; ends at the done-cycle negedge.
    task automatic watch(input string tag, input logic [11:0] exp, input bit poke);
        logic [11:0] got;
        int glitch;
        int nbusy;
        int ndone;
        got    = '0;
        glitch = 0;
        nbusy  = 0;
        ndone  = 0;
        for (int c = 0; c < NB * CPB; c++) begin
            @(negedge clk);
            if (poke && c == 4 * CPB) begin
                load = 1'b1;
                din  = 8'h00;
            end
            if (poke && c == 5 * CPB) load = 1'b0;
            if (c % CPB == 0) got[c / CPB] = txd;
            else if (txd !== got[c / CPB]) glitch++;
            if (busy !== 1'b1) nbusy++;
            if (done !== 1'b0) ndone++;
        end
        chk({tag, " bits"}, 32'(got), 32'(exp));
        chk({tag, " bit hold"}, 32'(glitch), 32'd0);
        chk({tag, " busy during frame"}, 32'(nbusy), 32'd0);
        chk({tag, " done during frame"}, 32'(ndone), 32'd0);
        @(negedge clk);
        chk({tag, " done pulse"}, 32'(done), 32'd1);
        chk({tag, " busy after"}, 32'(busy), 32'd0);
        chk({tag, " ready in done"}, 32'(ready), 32'd1);
        chk({tag, " txd after"}, 32'(txd), 32'd1);
    endtask

    initial begin
        int nev;

        // Reset with a load pending: nothing may start.
        rst  = 1'b0;
        load = 1'b1;
        din  = 8'hFF;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("reset txd", 32'(txd), 32'd1);
            chk("reset ready", 32'(ready), 32'd1);
            chk("reset busy", 32'(busy), 32'd0);
            chk("reset done", 32'(done), 32'd0);
        end
        rst  = 1'b1;
        load = 1'b0;
        @(negedge clk);
        chk("post reset busy", 32'(busy), 32'd0);
        chk("post reset txd", 32'(txd), 32'd1);

        // Basic frame 0xA5: 0,1,0,1,0,0,1,0,1,1 (+ parity 0 when enabled).
        @(negedge clk);
        launch("a5", 8'hA5);
`ifdef SERIAL_FRAME_TX_PARITY_EN
        watch("a5", {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 1'b0);
        @(negedge clk);
        chk("a5 done width", 32'(done), 32'd0);
        launch("07", 8'h07);
        watch("07", {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 1'b0);
`else
        watch("a5", 12'b00_1101001010, 1'b0);
        @(negedge clk);
        chk("a5 done width", 32'(done), 32'd0);
`endif

        // Back-to-back: load held in the done cycle of the first frame.
        @(negedge clk);
        launch("3c", 8'h3C);
        watch("3c", frame_bits(8'h3C), 1'b0);
        launch("c3", 8'hC3);
        watch("c3", frame_bits(8'hC3), 1'b0);

        // Load with a new din during DATA must not disturb the frame.
        @(negedge clk);
        launch("poke", 8'h96);
        watch("poke", frame_bits(8'h96), 1'b1);
        nev = 0;
        repeat (3 * CPB) begin
            @(negedge clk);
            if (busy !== 1'b0 || txd !== 1'b1 || done !== 1'b0) nev++;
        end
        chk("no extra frame", 32'(nev), 32'd0);

        // Reset during the third data bit (0x5A bit2 = 0).
        launch("abort", 8'h5A);
        repeat (3 * CPB + 2) @(negedge clk);
        chk("abort txd before", 32'(txd), 32'd0);
        chk("abort busy before", 32'(busy), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort txd", 32'(txd), 32'd1);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort ready", 32'(ready), 32'd1);
        chk("abort done", 32'(done), 32'd0);
        rst = 1'b1;
        nev = 0;
        repeat (NB * CPB + 4) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) nev++;
        end
        chk("abort no done", 32'(nev), 32'd0);
        launch("81", 8'h81);
        watch("81", frame_bits(8'h81), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
